// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit slice per clock, carry registered between nibbles.
// Operands in over valid/ready, registered sum/carry out over valid/ready.
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             busy
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [3:0]       nib_a, nib_b, sum_nib;
   logic             c_nib;

   // 4-bit full-adder slice on the nibble selected by idx
   always_comb begin
      nib_a          = 4'(a_q >> {idx_q, 2'b00});
      nib_b          = 4'(b_q >> {idx_q, 2'b00});
      {c_nib, sum_nib} = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ci;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = c_nib;
            for (int k = 0; k < N; k++) begin
               if (idx_q == IW'(k)) s_d[4*k +: 4] = sum_nib;
            end
            if (idx_q == IW'(N - 1)) state_d = DONE;
            else                     idx_d   = idx_q + IW'(1);
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
      end
   end

   // every output comes straight from a flop or from the state register
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN) || (state_q == DONE);
   assign s         = s_q;
   assign co        = carry_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboarded bench for nibble_serial_adder at WIDTH=16 plus a WIDTH=4 instance.
module tb_nibble_serial_adder;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, out_valid, out_ready, ci, co, busy;
   logic [15:0] a, b, s;
   logic        in_valid4, in_ready4, out_valid4, out_ready4, ci4, co4, busy4;
   logic [3:0]  a4, b4, s4;

   nibble_serial_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .busy(busy));

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .ci(ci4), .out_valid(out_valid4), .out_ready(out_ready4),
      .s(s4), .co(co4), .busy(busy4));

   typedef struct {
      logic [15:0] s;
      logic        co;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   sweep_on = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
      logic [16:0] full;
      exp_t e;
      full = {1'b0, x} + {1'b0, y} + {16'd0, c};
      e.s  = full[15:0];
      e.co = full[16];
      return e;
   endfunction

   // called at posedge+#1; returns at accept edge +#1
   task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c, input bit push);
      in_valid = 1'b1;
      a = x; b = y; ci = c;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) exp_q.push_back(model(x, y, c));
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
         end
      end
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 200; t++) begin
         if (exp_q.size() == 0) return;
         @(posedge clk); #1;
      end
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   // result consumer side of the scoreboard
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected", 1, 0);
         else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_s", s, e.s);
            chk("sb_co", co, e.co);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 0; a = 0; b = 0; ci = 0; out_ready = 1;
      in_valid4 = 0; a4 = 0; b4 = 0; ci4 = 0; out_ready4 = 1;
      repeat (2) @(posedge clk); #1;
      chk("rst_s", s, 0);
      chk("rst_co", co, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_irdy", in_ready, 1);
      chk("rst_irdy4", in_ready4, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // latency check on the first operation
      send(16'h1234, 16'h4321, 1'b0, 1'b1);
      chk("acc_busy", busy, 1);
      chk("acc_irdy", in_ready, 0);
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         chk("lat_early", out_valid, 0);
      end
      @(posedge clk); #1;
      chk("lat4_vld", out_valid, 1);
      chk("lat4_s", s, 16'h5555);
      drain();

      send(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
      drain();

      // back-pressure in DONE while upstream offers new data
      out_ready = 1'b0;
      send(16'hABCD, 16'h1111, 1'b0, 1'b1);
      for (int t = 0; t < 20 && !out_valid; t++) begin
         @(posedge clk); #1;
      end
      chk("stall_vld0", out_valid, 1);
      in_valid = 1'b1; a = 16'h0001; b = 16'h0002; ci = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("stall_s", s, 16'hBCDE);
         chk("stall_co", co, 0);
         chk("stall_irdy", in_ready, 0);
         chk("stall_vld", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("hs_vld", out_valid, 0);
      chk("hs_irdy", in_ready, 1);
      exp_q.push_back(model(16'h0001, 16'h0002, 1'b0));
      @(posedge clk); #1;
      chk("next_busy", busy, 1);
      chk("next_irdy", in_ready, 0);
      in_valid = 1'b0;
      drain();

      // asynchronous reset mid-operation discards it
      send(16'h0F0F, 16'h0101, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("arst_s", s, 0);
      chk("arst_co", co, 0);
      chk("arst_vld", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_irdy", in_ready, 1);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("arst_novld", out_valid, 0);
      end

      // single-nibble instance
      in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h8; ci4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      chk("w4_busy", busy4, 1);
      @(posedge clk); #1;
      chk("w4_vld", out_valid4, 1);
      chk("w4_s", s4, 4'h2);
      chk("w4_co", co4, 1);

      // random sweep with consumer stalls
      sweep_on = 1'b1;
      fork
         begin
            for (int i = 0; i < 200; i++)
               send(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            drain();
            sweep_on = 1'b0;
         end
         begin
            while (sweep_on) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

- Multi-nibble adder that computes a WIDTH-bit sum four bits per clock.
- Accepts a WIDTH-bit operand pair and carry-in over a valid/ready handshake.
- Each cycle, one 4-bit slice goes through an internal 4-bit full-adder slice; that slice behaves exactly like `fa4_mbit` (s, co from a, b, ci), and `fa4_mbit` may be instantiated directly.
- The slice's co is registered and chained into the next nibble.
- Sits around the existing 4-bit adders: feeds them operand slices and collects their s/co into a wide result, giving the datapath 8/16/32-bit addition without a wide combinational carry chain.

## Interface
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and ≥ 4. N = WIDTH/4 nibbles.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  operand pair on a/b/ci is valid.
- in_ready  output  1  block can accept operands. Equals (state == IDLE).
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in to nibble 0.
- out_valid  output  1  s/co hold a complete result. Equals (state == DONE).
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum, registered.
- co  output  1  carry-out of nibble N-1, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers:
  - a_r, b_r: WIDTH bits each.
  - carry_r: 1 bit.
  - idx: ceil(log2(N)) bits, minimum 1.
  - s_r: WIDTH bits.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: a_r ← a, b_r ← b, carry_r ← ci, idx ← 0, go to RUN.
  - Otherwise stay; inputs are ignored.
- RUN, one nibble per cycle:
  - {c, sum4} = a_r[4·idx+3 : 4·idx] + b_r[4·idx+3 : 4·idx] + carry_r.
  - s_r[4·idx+3 : 4·idx] ← sum4; carry_r ← c.
  - If idx == N-1: go to DONE. Else idx ← idx+1.
- DONE:
  - out_valid = 1; s = s_r; co = carry_r.
  - On out_valid && out_ready: go to IDLE.
  - s and co stay stable for as long as out_ready is low.
- Arithmetic: the result equals (a + b + ci) mod 2^WIDTH, with co = bit WIDTH of the full sum. Operands are unsigned; there is no overflow flag.
- Carry chains through every nibble. Nibble k's carry-in is nibble k-1's carry-out; nibble 0's is ci.
- in_valid and in_ready low in RUN/DONE: nothing is latched and nothing is lost on the upstream side; upstream holds its data.
- The s/co pins always show s_r/carry_r. Their values are meaningful only while out_valid = 1.
  - During RUN, s is partially updated and co carries the intermediate carry.
- Reset, asynchronous, any state: state ← IDLE and all registers ← 0. Resulting outputs:
  - s = 0, co = 0.
  - out_valid = 0, busy = 0.
  - in_ready = 1.
  - An operation in progress is discarded with no output.
- N = 1 (WIDTH = 4): RUN lasts exactly one cycle.

## Timing
- Accept edge E0 (in_valid && in_ready sampled high): state = RUN after E0; in_ready falls immediately after E0.
- Edges E1..EN compute nibbles 0..N-1.
- out_valid rises after EN. Latency from accept to out_valid is N clocks (4 for WIDTH=16).
- Result handoff edge Eh (out_valid && out_ready): out_valid falls and in_ready rises after Eh.
- The earliest next accept is edge Eh+1. There is no accept on the same edge as the result handoff.
- Throughput with out_ready tied high: one operation per N+2 clocks.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- WIDTH=16:
  - Reset, then a=0x1234, b=0x4321, ci=0 → out_valid exactly 4 clocks after accept; s=0x5555, co=0.
  - a=0xFFFF, b=0x0001, ci=0 → s=0x0000, co=1. Carry ripples through all four nibbles.
  - a=0xFFFF, b=0xFFFF, ci=1 → s=0xFFFF, co=1.
  - out_ready held low 5 clocks in DONE while in_valid=1 with new data → s/co unchanged, in_ready=0, no new accept. Drop to IDLE one clock after out_ready=1; new operand accepted the following edge.
  - Assert rst_n=0 asynchronously after E2 of a=0x0F0F, b=0x0101 → immediately s=0, co=0, out_valid=0, busy=0, in_ready=1. No result is ever presented for that operation.
- WIDTH=4: a=0x9, b=0x8, ci=1 → s=0x2, co=1 one clock after accept.
- Random sweep: 200 random {ci, a, b} with random out_ready stalls → every result equals a+b+ci compared against a reference model.
